// File: rtl/opcode_type_pkg.sv
// Shared RV32I opcode, controller state and select encodings for the multi-cycle core.
package opcode_type_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OPIMM  = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } opcode_type_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_IMM   = 2'b01,
        PC_ALU   = 2'b10
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    typedef enum logic [3:0] {
        CL_OP, CL_OPIMM, CL_LUI, CL_AUIPC, CL_JAL,
        CL_JALR, CL_BR, CL_LD, CL_ST, CL_ILL
    } instr_class_e;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: instr[6:0] -> instruction class, anything unknown is CL_ILL.
module ctrl_decode
    import opcode_type_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_e cls
);

    always_comb begin
        cls = CL_ILL;
        case (opcode)
            OPC_OP:     cls = CL_OP;
            OPC_OPIMM:  cls = CL_OPIMM;
            OPC_LUI:    cls = CL_LUI;
            OPC_AUIPC:  cls = CL_AUIPC;
            OPC_JAL:    cls = CL_JAL;
            OPC_JALR:   cls = CL_JALR;
            OPC_BRANCH: cls = CL_BR;
            OPC_LOAD:   cls = CL_LD;
            OPC_STORE:  cls = CL_ST;
            default:    cls = CL_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with req/ack memory.
// Optional memory handshake timeout is enabled by defining MEM_TIMEOUT_EN.
module multicycle_ctrl
    import opcode_type_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ack,
    input  logic        br_taken,
    output logic        ir_we,
    output logic        imm_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_W < 1) begin : g_param_chk
        $error("multicycle_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    ctrl_state_e  state_q, state_d;
    instr_class_e cls;
    logic         illegal_q, bus_err_q;
    logic         waiting, tmo_fire;
    logic         unused_instr;

    assign unused_instr = ^instr[31:7];

    ctrl_decode u_decode (
        .opcode (instr[6:0]),
        .cls    (cls)
    );

    // A request cycle that was not acknowledged.
    assign waiting = (state_q == S_FETCH || state_q == S_MEM) && !mem_ack;

`ifdef MEM_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt;

    // Fires on the TIMEOUT_CYCLES-th consecutive unacked cycle; an ack that cycle wins.
    assign tmo_fire = waiting && (tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= '0;
        else if (waiting && state_d == state_q)
            tmo_cnt <= tmo_cnt + 1'b1;
        else
            tmo_cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            bus_err_q <= 1'b0;
        else if (tmo_fire)
            bus_err_q <= 1'b1;
    end
`else
    assign tmo_fire  = 1'b0;
    assign bus_err_q = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE && cls == CL_ILL)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        ir_we        = 1'b0;
        imm_we       = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;

        // ALU operands stay valid from EXEC through MEM/WB so address and result hold.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_a_sel = (cls == CL_AUIPC);
            alu_b_sel = cls inside {CL_OPIMM, CL_LD, CL_ST, CL_JALR, CL_AUIPC};
        end

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_fire) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                imm_we  = 1'b1;
                state_d = (cls == CL_ILL) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    CL_LD, CL_ST: state_d = S_MEM;
                    CL_BR: begin
                        pc_we   = 1'b1;
                        pc_sel  = br_taken ? PC_IMM : PC_PLUS4;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls == CL_ST);
                if (mem_ack) begin
                    if (cls == CL_ST) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo_fire) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_FETCH;
                case (cls)
                    CL_LD:           wb_sel = WB_MEM;
                    CL_JAL, CL_JALR: wb_sel = WB_PC4;
                    CL_LUI:          wb_sel = WB_IMM;
                    default:         wb_sel = WB_ALU;
                endcase
                if (cls == CL_JAL)       pc_sel = PC_IMM;
                else if (cls == CL_JALR) pc_sel = PC_ALU;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        if (rst) begin
            ir_we        = 1'b0;
            imm_we       = 1'b0;
            pc_we        = 1'b0;
            pc_sel       = PC_PLUS4;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            alu_a_sel    = 1'b0;
            alu_b_sel    = 1'b0;
            rf_we        = 1'b0;
            wb_sel       = WB_ALU;
        end
    end

    assign state   = rst ? 3'd0 : state_q;
    assign illegal = illegal_q & ~rst;
    assign bus_err = bus_err_q & ~rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl; MEM_TIMEOUT_EN selects the timeout scenario.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst, mem_ack, br_taken;
    logic [31:0] instr;
    logic        ir_we, imm_we, pc_we, mem_req, mem_we, mem_addr_sel;
    logic        alu_a_sel, alu_b_sel, rf_we, illegal, bus_err;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  state;
    logic [17:0] obs;
    int          total = 0;
    int          bad   = 0;

    // Bit order: ir imm pcwe pcsel(2) req we asel a b rfwe wbsel(2) ill berr state(3)
    localparam logic [17:0] F_ACK  = 18'b1_0_0_00_1_0_0_0_0_0_00_0_0_000;
    localparam logic [17:0] F_IDLE = 18'b0_0_0_00_1_0_0_0_0_0_00_0_0_000;
    localparam logic [17:0] DEC    = 18'b0_1_0_00_0_0_0_0_0_0_00_0_0_001;
    localparam logic [17:0] EX_0   = 18'b0_0_0_00_0_0_0_0_0_0_00_0_0_010;
    localparam logic [17:0] EX_B   = 18'b0_0_0_00_0_0_0_0_1_0_00_0_0_010;
    localparam logic [17:0] ZERO   = 18'b0;
    localparam logic [17:0] TRAP_I = 18'b0_0_0_00_0_0_0_0_0_0_00_1_0_111;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LW   = 32'h0000A103;
    localparam logic [31:0] BEQ  = 32'h00000463;
    localparam logic [31:0] JALR = 32'h000280E7;
    localparam logic [31:0] SW   = 32'h0020A023;

    always #5 clk = ~clk;

    assign obs = {ir_we, imm_we, pc_we, pc_sel, mem_req, mem_we, mem_addr_sel,
                  alu_a_sel, alu_b_sel, rf_we, wb_sel, illegal, bus_err, state};

    multicycle_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ack(mem_ack), .br_taken(br_taken),
        .ir_we(ir_we), .imm_we(imm_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic r, input logic a, input logic b, input logic [31:0] ins);
        @(negedge clk);
        rst = r; mem_ack = a; br_taken = b; instr = ins;
        #1;
    endtask

    task automatic test_reset;
        drive(1, 1, 0, ADDI);
        total++;
        if (obs !== ZERO) begin $display("FAIL reset_force got=%b exp=%b", obs, ZERO); bad++; end
        drive(1, 1, 1, ADDI);
        total++;
        if (obs !== ZERO) begin $display("FAIL reset_hold got=%b exp=%b", obs, ZERO); bad++; end
        drive(0, 0, 0, ADDI);
        total++;
        if (obs !== F_IDLE) begin $display("FAIL reset_exit got=%b exp=%b", obs, F_IDLE); bad++; end
    endtask

    task automatic test_addi;
        logic [17:0] exp [5] = '{F_ACK, DEC, EX_B, 18'b0_0_1_00_0_0_0_0_1_1_00_0_0_100, F_IDLE};
        bit          ak  [5] = '{1, 0, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            drive(0, ak[i], 0, ADDI);
            total++;
            if (obs !== exp[i]) begin
                $display("FAIL addi cyc%0d got=%b exp=%b", i, obs, exp[i]); bad++;
            end
        end
    endtask

    task automatic test_load_wait;
        logic [17:0] mem_ld = 18'b0_0_0_00_1_0_1_0_1_0_00_0_0_011;
        logic [17:0] exp [8] = '{F_ACK, DEC, EX_B, mem_ld, mem_ld, mem_ld,
                                 18'b0_0_1_00_0_0_0_0_1_1_01_0_0_100, F_IDLE};
        bit          ak  [8] = '{1, 0, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            drive(0, ak[i], 0, LW);
            total++;
            if (obs !== exp[i]) begin
                $display("FAIL load_wait cyc%0d got=%b exp=%b", i, obs, exp[i]); bad++;
            end
        end
    endtask

    task automatic test_branch;
        for (int t = 1; t >= 0; t--) begin
            logic [17:0] ex_br = (t == 1) ? 18'b0_0_1_01_0_0_0_0_0_0_00_0_0_010
                                          : 18'b0_0_1_00_0_0_0_0_0_0_00_0_0_010;
            logic [17:0] exp [4] = '{F_ACK, DEC, ex_br, F_IDLE};
            bit          ak  [4] = '{1, 0, 0, 0};
            for (int i = 0; i < 4; i++) begin
                drive(0, ak[i], 1'(t), BEQ);
                total++;
                if (obs !== exp[i]) begin
                    $display("FAIL branch_t%0d cyc%0d got=%b exp=%b", t, i, obs, exp[i]); bad++;
                end
            end
        end
    endtask

    task automatic test_jalr_store;
        logic [17:0] exp [10] = '{F_ACK, DEC, EX_B, 18'b0_0_1_10_0_0_0_0_1_1_10_0_0_100, F_ACK,
                                  DEC, EX_B, 18'b0_0_1_00_1_1_1_0_1_0_00_0_0_011, F_IDLE, F_IDLE};
        bit          ak  [10] = '{1, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        logic [31:0] ins [10] = '{JALR, JALR, JALR, JALR, SW, SW, SW, SW, SW, SW};
        for (int i = 0; i < 10; i++) begin
            drive(0, ak[i], 0, ins[i]);
            total++;
            if (obs !== exp[i]) begin
                $display("FAIL jalr_store cyc%0d got=%b exp=%b", i, obs, exp[i]); bad++;
            end
        end
    endtask

    task automatic test_back_to_back;
        // LUI, AUIPC, JAL, OP issued with zero-wait fetches
        logic [31:0] ops [4] = '{32'h000000B7, 32'h00000097, 32'h0000006F, 32'h002081B3};
        logic [17:0] ex  [4] = '{EX_0, 18'b0_0_0_00_0_0_0_1_1_0_00_0_0_010, EX_0, EX_0};
        logic [17:0] wb  [4] = '{18'b0_0_1_00_0_0_0_0_0_1_11_0_0_100,
                                 18'b0_0_1_00_0_0_0_1_1_1_00_0_0_100,
                                 18'b0_0_1_01_0_0_0_0_0_1_10_0_0_100,
                                 18'b0_0_1_00_0_0_0_0_0_1_00_0_0_100};
        for (int k = 0; k < 4; k++) begin
            logic [17:0] exp [4] = '{F_ACK, DEC, ex[k], wb[k]};
            for (int i = 0; i < 4; i++) begin
                drive(0, (i == 0), 0, ops[k]);
                total++;
                if (obs !== exp[i]) begin
                    $display("FAIL b2b_op%0d cyc%0d got=%b exp=%b", k, i, obs, exp[i]); bad++;
                end
            end
        end
        drive(0, 0, 0, ADDI);
        total++;
        if (obs !== F_IDLE) begin $display("FAIL b2b_end got=%b exp=%b", obs, F_IDLE); bad++; end
    endtask

    task automatic test_reset_mid;
        drive(0, 1, 0, LW);
        drive(0, 0, 0, LW);
        drive(0, 0, 0, LW);
        drive(0, 0, 0, LW);
        total++;
        if (state !== 3'd3) begin $display("FAIL midrst_mem got=%0d exp=3", state); bad++; end
        drive(1, 0, 0, LW);
        total++;
        if (obs !== ZERO) begin $display("FAIL midrst_force got=%b exp=%b", obs, ZERO); bad++; end
        drive(0, 0, 0, LW);
        total++;
        if (obs !== F_IDLE) begin $display("FAIL midrst_fetch got=%b exp=%b", obs, F_IDLE); bad++; end
    endtask

    task automatic test_trap;
        drive(0, 1, 0, 32'h0000007F);
        total++;
        if (obs !== F_ACK) begin $display("FAIL trap_fetch got=%b exp=%b", obs, F_ACK); bad++; end
        drive(0, 0, 0, 32'h0000007F);
        total++;
        if (obs !== DEC) begin $display("FAIL trap_dec got=%b exp=%b", obs, DEC); bad++; end
        for (int i = 0; i < 100; i++) begin
            drive(0, 1'(i), 1'(i >> 1), 32'h0000007F);
            total++;
            if (obs !== TRAP_I) begin
                $display("FAIL trap_hold cyc%0d got=%b exp=%b", i, obs, TRAP_I); bad++;
            end
        end
        drive(1, 0, 0, 32'h0000007F);
        total++;
        if (obs !== ZERO) begin $display("FAIL trap_rst got=%b exp=%b", obs, ZERO); bad++; end
        drive(0, 0, 0, ADDI);
        total++;
        if (obs !== F_IDLE) begin $display("FAIL trap_exit got=%b exp=%b", obs, F_IDLE); bad++; end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        drive(1, 0, 0, ADDI);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, ADDI);
            total++;
            if (obs !== F_IDLE) begin $display("FAIL tmo_wait%0d got=%b exp=%b", i, obs, F_IDLE); bad++; end
        end
        drive(0, 0, 0, ADDI);
        total++;
        if (obs !== 18'b0_0_0_00_0_0_0_0_0_0_00_0_1_111) begin
            $display("FAIL tmo_trap got=%b exp=%b", obs, 18'b0_0_0_00_0_0_0_0_0_0_00_0_1_111); bad++;
        end
        drive(1, 0, 0, ADDI);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, ADDI);
        drive(0, 1, 0, ADDI);
        total++;
        if (obs !== F_ACK) begin $display("FAIL tmo_late_ack got=%b exp=%b", obs, F_ACK); bad++; end
        drive(0, 0, 0, ADDI);
        total++;
        if (obs !== DEC) begin $display("FAIL tmo_no_err got=%b exp=%b", obs, DEC); bad++; end
    endtask
`else
    task automatic test_timeout;
        drive(1, 0, 0, ADDI);
        for (int i = 0; i < 300; i++) begin
            drive(0, 0, 0, ADDI);
            if (i % 50 == 49) begin
                total++;
                if (obs !== F_IDLE) begin
                    $display("FAIL no_tmo_wait%0d got=%b exp=%b", i, obs, F_IDLE); bad++;
                end
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; mem_ack = 1'b0; br_taken = 1'b0; instr = '0;
        test_reset;
        test_addi;
        test_load_wait;
        test_branch;
        test_jalr_store;
        test_back_to_back;
        test_reset_mid;
        test_trap;
        test_timeout;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
